// File: rtl/gcd.sv
// Subtractive-Euclid GCD engine: one subtraction per clock, START/DONE handshake.
// DONE pulses after edge k+N+2 (N subtractions), or k+1 when an operand is zero.
module gcd #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             DONE,
  output logic             ERROR
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_x, w_x_nxt;
  logic [WIDTH-1:0] r_z, w_z_nxt;
  logic [WIDTH-1:0] r_y, w_y_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_err_pend, w_err_pend_nxt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_z        <= '0;
      r_y        <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_x        <= w_x_nxt;
      r_z        <= w_z_nxt;
      r_y        <= w_y_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_pend <= w_err_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_x_nxt        = r_x;
    w_z_nxt        = r_z;
    w_y_nxt        = r_y;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_err_pend_nxt = r_err_pend;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_x_nxt        = A;
          w_z_nxt        = B;
          w_y_nxt        = '0;
          w_err_nxt      = 1'b0;
          w_err_pend_nxt = (A == '0) || (B == '0);
          w_state_nxt    = ((A == '0) || (B == '0)) ? FIN : CALC;
        end
      end
      CALC: begin
        // Larger operand is always the minuend, so no underflow.
        if (r_x == r_z) begin
          w_y_nxt     = r_x;
          w_state_nxt = FIN;
        end else if (r_x > r_z) begin
          w_x_nxt = r_x - r_z;
        end else begin
          w_z_nxt = r_z - r_x;
        end
      end
      FIN: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
        if (r_err_pend) begin
          w_err_nxt = 1'b1;
          w_y_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign Y     = r_y;
  assign DONE  = r_done;
  assign ERROR = r_err;

endmodule

// File: tb/tb_gcd.sv
// Randomized + directed bench for gcd against a cycle-level behavioural model.
module tb_gcd;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Y;
  logic         DONE;
  logic         ERROR;

  gcd #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .Y(Y), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int ref_steps(input int a, input int b);
    int n = 0;
    while (a != b) begin
      if (a > b) a = a - b;
      else b = b - a;
      n++;
    end
    return n;
  endfunction

  // Behavioural model: when an op is accepted, compute result and event edges up front.
  bit           m_started = 0;
  bit           m_busy = 0;
  bit           m_done = 0;
  bit           m_err = 0;
  bit           m_err_pend = 0;
  logic [W-1:0] m_y = '0;
  logic [W-1:0] m_g = '0;
  int           cyc = 0;
  int           m_done_edge = 0;
  int           m_y_edge = 0;

  always @(posedge CLK) begin
    int n;
    cyc++;
    m_started = 1;
    m_done = 0;
    if (!RST_N) begin
      m_busy = 0;
      m_y = '0;
      m_err = 0;
    end else if (m_busy) begin
      if (!m_err_pend && cyc == m_y_edge) m_y = m_g;
      if (cyc == m_done_edge) begin
        m_done = 1;
        m_busy = 0;
        m_err = m_err_pend;
      end
    end else if (START) begin
      m_busy = 1;
      m_y = '0;
      m_err = 0;
      m_err_pend = (A == 0) || (B == 0);
      if (m_err_pend) begin
        m_done_edge = cyc + 1;
      end else begin
        n = ref_steps(int'(A), int'(B));
        m_y_edge = cyc + n + 1;
        m_done_edge = cyc + n + 2;
        m_g = W'(ref_gcd(int'(A), int'(B)));
      end
    end
  end

  always @(negedge CLK) begin
    if (m_started) begin
      check("done", DONE, m_done);
      check("y", Y, m_y);
      check("error", ERROR, m_err);
    end
  end

  task automatic run_op(input int a, input int b, input int exp_lat, input int exp_y, input int exp_err);
    int n;
    A = W'(a);
    B = W'(b);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    n = 0;
    while (!DONE && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("latency", n, exp_lat);
    check("op_y", Y, exp_y);
    check("op_error", ERROR, exp_err);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", m_busy, 0);
  endtask

  initial begin
    int a, b, n;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_y", Y, 0);
    check("rst_done", DONE, 0);
    check("rst_error", ERROR, 0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    check("model_gcd_21_6", ref_gcd(21, 6), 3);
    check("model_steps_21_6", ref_steps(21, 6), 4);
    check("model_gcd_75_60", ref_gcd(75, 60), 15);
    check("model_steps_29_8", ref_steps(29, 8), 7);
    check("model_steps_99_11", ref_steps(99, 11), 8);
    check("model_steps_255_1", ref_steps(255, 1), 254);

    run_op(21, 6, 6, 3, 0);
    run_op(75, 60, 6, 15, 0);
    run_op(29, 8, 9, 1, 0);
    run_op(99, 11, 10, 11, 0);
    run_op(255, 1, 256, 1, 0);
    run_op(1, 255, 256, 1, 0);
    run_op(103, 103, 2, 103, 0);
    repeat (5) @(negedge CLK);
    check("y_hold", Y, 103);

    run_op(0, 5, 1, 0, 1);
    run_op(0, 0, 1, 0, 1);
    run_op(12, 18, 4, 6, 0);

    // START pulse while busy must be ignored
    A = 8'd29; B = 8'd8; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    A = 8'd48; B = 8'd18; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 0;
    while (!DONE && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("busy_ignore_done", DONE, 1);
    check("busy_ignore_y", Y, 1);
    @(negedge CLK);

    // Reset mid-computation aborts without DONE
    A = 8'd255; B = 8'd1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (20) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    check("abort_y", Y, 0);
    check("abort_done", DONE, 0);
    RST_N = 1'b1;
    repeat (300) @(negedge CLK);
    run_op(21, 6, 6, 3, 0);

    // START held high: back-to-back operations
    A = 8'd9; B = 8'd6; START = 1'b1;
    repeat (30) @(negedge CLK);
    A = 8'd0;
    repeat (8) @(negedge CLK);
    START = 1'b0;
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      if (a == 0 || b == 0) run_op(a, b, 1, 0, 1);
      else run_op(a, b, ref_steps(a, b) + 2, ref_gcd(a, b), 0);
    end

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
